// File: rtl/ps_switch_ctrl_if.sv
// rtl/ps_switch_ctrl_if.sv - request/handshake/state bundle for ps_switch_ctrl
interface ps_switch_ctrl_if;
    logic        i_req;
    logic        o_req_ready;
    logic [1:0]  i_new_priv;
    logic        i_new_isa_c;
    logic [31:0] i_new_satp;
    logic [31:0] i_new_status;
    logic        i_force_flush;
    logic        i_pipe_empty;
    logic        o_tlb_flush;
    logic        i_tlb_flush_ack;
    logic        o_stall_fetch;
    logic [1:0]  o_priv;
    logic        o_isa_c;
    logic [31:0] o_satp;
    logic [31:0] o_status;
    logic        o_done;

    // Requester / pipeline side
    modport master (
        output i_req, i_new_priv, i_new_isa_c, i_new_satp, i_new_status,
               i_force_flush, i_pipe_empty, i_tlb_flush_ack,
        input  o_req_ready, o_tlb_flush, o_stall_fetch, o_priv, o_isa_c,
               o_satp, o_status, o_done
    );

    // Controller side
    modport slave (
        input  i_req, i_new_priv, i_new_isa_c, i_new_satp, i_new_status,
               i_force_flush, i_pipe_empty, i_tlb_flush_ack,
        output o_req_ready, o_tlb_flush, o_stall_fetch, o_priv, o_isa_c,
               o_satp, o_status, o_done
    );
endinterface

// File: rtl/ps_switch_ctrl.sv
// rtl/ps_switch_ctrl.sv - sequences atomic priv/isa_c/satp/status changes with drain, TLB flush and settle
module ps_switch_ctrl #(
    parameter logic [1:0] RESET_PRIV    = 2'b11,
    parameter logic       RESET_ISA_C   = 1'b1,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    ps_switch_ctrl_if.slave bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DRAIN  = 3'd1;
    localparam logic [2:0] FLUSH  = 3'd2;
    localparam logic [2:0] COMMIT = 3'd3;
    localparam logic [2:0] SETTLE = 3'd4;

    localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

    logic [2:0]    state_q,      state_d;
    logic [1:0]    priv_q,       priv_d;
    logic          isa_c_q,      isa_c_d;
    logic [31:0]   satp_q,       satp_d;
    logic [31:0]   status_q,     status_d;
    logic [1:0]    lat_priv_q,   lat_priv_d;
    logic          lat_isa_c_q,  lat_isa_c_d;
    logic [31:0]   lat_satp_q,   lat_satp_d;
    logic [31:0]   lat_status_q, lat_status_d;
    logic          lat_force_q,  lat_force_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic          stall_q,      stall_d;
    logic          flush_q,      flush_d;
    logic          done_q,       done_d;
    logic          need_flush;

    // Translation context changes if satp moves, or privilege moves while either side has paging on
    always_comb begin
        need_flush = lat_force_q
                   | (lat_satp_q != satp_q)
                   | ((lat_priv_q != priv_q) & (satp_q[31] | lat_satp_q[31]));
    end

    // Next-state, latch and commit logic; registered outputs are derived from the next state
    always_comb begin
        state_d      = state_q;
        priv_d       = priv_q;
        isa_c_d      = isa_c_q;
        satp_d       = satp_q;
        status_d     = status_q;
        lat_priv_d   = lat_priv_q;
        lat_isa_c_d  = lat_isa_c_q;
        lat_satp_d   = lat_satp_q;
        lat_status_d = lat_status_q;
        lat_force_d  = lat_force_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.i_req) begin
                    lat_priv_d   = bus.i_new_priv;
                    lat_isa_c_d  = bus.i_new_isa_c;
                    lat_satp_d   = bus.i_new_satp;
                    lat_status_d = bus.i_new_status;
                    lat_force_d  = bus.i_force_flush;
                    state_d      = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.i_pipe_empty) begin
                    state_d = need_flush ? FLUSH : COMMIT;
                end
            end
            FLUSH: begin
                if (bus.i_tlb_flush_ack) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                priv_d   = lat_priv_q;
                isa_c_d  = lat_isa_c_q;
                satp_d   = lat_satp_q;
                status_d = lat_status_q;
                if (SETTLE_CYCLES > 0) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        stall_d = (state_d != IDLE);
        flush_d = (state_d == FLUSH);
        done_d  = (state_d == IDLE) && ((state_q == COMMIT) || (state_q == SETTLE));
    end

    // State, architectural registers and registered handshake outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            priv_q       <= RESET_PRIV;
            isa_c_q      <= RESET_ISA_C;
            satp_q       <= '0;
            status_q     <= '0;
            lat_priv_q   <= '0;
            lat_isa_c_q  <= 1'b0;
            lat_satp_q   <= '0;
            lat_status_q <= '0;
            lat_force_q  <= 1'b0;
            cnt_q        <= '0;
            stall_q      <= 1'b0;
            flush_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            priv_q       <= priv_d;
            isa_c_q      <= isa_c_d;
            satp_q       <= satp_d;
            status_q     <= status_d;
            lat_priv_q   <= lat_priv_d;
            lat_isa_c_q  <= lat_isa_c_d;
            lat_satp_q   <= lat_satp_d;
            lat_status_q <= lat_status_d;
            lat_force_q  <= lat_force_d;
            cnt_q        <= cnt_d;
            stall_q      <= stall_d;
            flush_q      <= flush_d;
            done_q       <= done_d;
        end
    end

    assign bus.o_req_ready   = (state_q == IDLE);
    assign bus.o_stall_fetch = stall_q;
    assign bus.o_tlb_flush   = flush_q;
    assign bus.o_done        = done_q;
    assign bus.o_priv        = priv_q;
    assign bus.o_isa_c       = isa_c_q;
    assign bus.o_satp        = satp_q;
    assign bus.o_status      = status_q;

endmodule

// File: tb/tb_ps_switch_ctrl.sv
// tb/tb_ps_switch_ctrl.sv - self-checking bench for ps_switch_ctrl against a timeline reference model
module tb_ps_switch_ctrl;

    localparam int SETTLE = 2;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    bit   done_pending;

    logic [1:0]  m_priv;
    logic        m_isa_c;
    logic [31:0] m_satp;
    logic [31:0] m_status;

    ps_switch_ctrl_if bus ();

    ps_switch_ctrl #(
        .RESET_PRIV    (2'b11),
        .RESET_ISA_C   (1'b1),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input logic [1:0] p, input logic c, input logic [31:0] s, input logic [31:0] st);
        chk("priv",   {30'd0, bus.o_priv},  {30'd0, p});
        chk("isa_c",  {31'd0, bus.o_isa_c}, {31'd0, c});
        chk("satp",   bus.o_satp,           s);
        chk("status", bus.o_status,         st);
    endtask

    task automatic model_reset();
        m_priv       = 2'b11;
        m_isa_c      = 1'b1;
        m_satp       = 32'd0;
        m_status     = 32'd0;
        done_pending = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.i_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.i_tlb_flush_ack = 1'($urandom_range(0, 1));
            bus.i_pipe_empty    = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_ready", {31'd0, bus.o_req_ready},   32'd1);
            chk("idle_stall", {31'd0, bus.o_stall_fetch}, 32'd0);
            chk("idle_flush", {31'd0, bus.o_tlb_flush},   32'd0);
            chk("idle_done",  {31'd0, bus.o_done},        {31'd0, done_pending});
            chk_regs(m_priv, m_isa_c, m_satp, m_status);
            done_pending = 1'b0;
            @(posedge clk); #1;
        end
        bus.i_tlb_flush_ack = 1'b0;
    endtask

    // One change sequence: nd = cycles with pipe not empty, ad = ack delay after flush rises.
    // hold keeps i_req asserted during busy so the next request is taken in the done cycle.
    task automatic run_change(input logic [1:0] p, input logic c, input logic [31:0] s,
                              input logic [31:0] st, input logic ff, input int nd, input int ad,
                              input bit hold, input bit spur);
        bit need;
        int f0, kc, kdone;
        need  = ff | (s != m_satp) | ((p != m_priv) & (m_satp[31] | s[31]));
        f0    = nd + 2;
        kc    = f0 + (need ? ad + 1 : 0);
        kdone = kc + 1 + SETTLE;

        bus.i_req           = 1'b1;
        bus.i_new_priv      = p;
        bus.i_new_isa_c     = c;
        bus.i_new_satp      = s;
        bus.i_new_status    = st;
        bus.i_force_flush   = ff;
        bus.i_pipe_empty    = (nd == 0);
        bus.i_tlb_flush_ack = 1'b0;
        @(negedge clk);
        chk("acc_ready", {31'd0, bus.o_req_ready},   32'd1);
        chk("acc_stall", {31'd0, bus.o_stall_fetch}, 32'd0);
        chk("acc_flush", {31'd0, bus.o_tlb_flush},   32'd0);
        chk("acc_done",  {31'd0, bus.o_done},        {31'd0, done_pending});
        chk_regs(m_priv, m_isa_c, m_satp, m_status);
        done_pending = 1'b0;
        @(posedge clk); #1;

        for (int k = 1; k < kdone; k++) begin
            bus.i_req         = hold;
            bus.i_new_priv    = 2'($urandom);
            bus.i_new_isa_c   = 1'($urandom);
            bus.i_new_satp    = $urandom;
            bus.i_new_status  = $urandom;
            bus.i_force_flush = 1'($urandom);
            if (k <= nd)            bus.i_pipe_empty = 1'b0;
            else if (k == nd + 1)   bus.i_pipe_empty = 1'b1;
            else                    bus.i_pipe_empty = 1'($urandom);
            bus.i_tlb_flush_ack = (need && k == f0 + ad) || (spur && k == 1);
            @(negedge clk);
            chk("busy_ready", {31'd0, bus.o_req_ready},   32'd0);
            chk("busy_stall", {31'd0, bus.o_stall_fetch}, 32'd1);
            chk("busy_done",  {31'd0, bus.o_done},        32'd0);
            chk("busy_flush", {31'd0, bus.o_tlb_flush},
                {31'd0, (need && k >= f0 && k <= f0 + ad)});
            if (k <= kc) chk_regs(m_priv, m_isa_c, m_satp, m_status);
            else         chk_regs(p, c, s, st);
            @(posedge clk); #1;
        end

        bus.i_tlb_flush_ack = 1'b0;
        bus.i_req           = hold;
        m_priv       = p;
        m_isa_c      = c;
        m_satp       = s;
        m_status     = st;
        done_pending = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_reset();
        rst_n               = 1'b0;
        bus.i_req           = 1'b0;
        bus.i_new_priv      = 2'd0;
        bus.i_new_isa_c     = 1'b0;
        bus.i_new_satp      = 32'd0;
        bus.i_new_status    = 32'd0;
        bus.i_force_flush   = 1'b0;
        bus.i_pipe_empty    = 1'b1;
        bus.i_tlb_flush_ack = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.o_req_ready},   32'd1);
        chk("rst_stall", {31'd0, bus.o_stall_fetch}, 32'd0);
        chk("rst_flush", {31'd0, bus.o_tlb_flush},   32'd0);
        chk("rst_done",  {31'd0, bus.o_done},        32'd0);
        chk_regs(2'b11, 1'b1, 32'd0, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Status-only change, no flush, fixed latency
        run_change(2'b11, 1'b1, 32'd0, 32'h8, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(2);
        // satp change with 3-cycle ack delay and a stray ack during DRAIN
        run_change(2'b11, 1'b1, 32'h8000_0123, 32'h8, 1'b0, 0, 3, 1'b0, 1'b1);
        idle(1);
        // Privilege drop with paging on and identical satp
        run_change(2'b01, 1'b1, 32'h8000_0123, 32'h8, 1'b0, 0, 1, 1'b0, 1'b0);
        idle(1);
        // Move to bare satp, then privilege change with paging off
        run_change(2'b01, 1'b1, 32'h0000_0123, 32'h8, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(1);
        run_change(2'b11, 1'b1, 32'h0000_0123, 32'h8, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(1);
        // Forced flush with identical values
        run_change(2'b11, 1'b1, 32'h0000_0123, 32'h8, 1'b1, 0, 2, 1'b0, 1'b0);
        idle(1);
        // Pipe busy for 5 cycles after accept
        run_change(2'b11, 1'b0, 32'h0000_0123, 32'h18, 1'b0, 5, 0, 1'b0, 1'b0);
        idle(1);
        // Request held during busy, accepted in the done cycle
        run_change(2'b00, 1'b1, 32'h0000_0123, 32'h55, 1'b0, 1, 0, 1'b1, 1'b0);
        run_change(2'b01, 1'b0, 32'h8000_0456, 32'h66, 1'b0, 0, 1, 1'b0, 1'b0);
        idle(2);

        // Reset mid-FLUSH: no commit, flush dropped immediately
        bus.i_req        = 1'b1;
        bus.i_new_priv   = 2'b00;
        bus.i_new_isa_c  = 1'b0;
        bus.i_new_satp   = 32'h1234_5678;
        bus.i_new_status = 32'hABCD;
        bus.i_force_flush = 1'b0;
        bus.i_pipe_empty = 1'b1;
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("pre_rst_flush", {31'd0, bus.o_tlb_flush}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flush", {31'd0, bus.o_tlb_flush},   32'd0);
        chk("mid_rst_stall", {31'd0, bus.o_stall_fetch}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.o_req_ready},   32'd1);
        chk("mid_rst_done",  {31'd0, bus.o_done},        32'd0);
        chk_regs(2'b11, 1'b1, 32'd0, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Randomized change sequences
        for (int i = 0; i < 40; i++) begin
            logic [31:0] s;
            int          sel;
            bit          hold;
            sel = $urandom_range(0, 3);
            if (sel == 0)      s = m_satp;
            else if (sel == 1) s = m_satp ^ 32'h8000_0000;
            else               s = $urandom;
            hold = (i != 39) && ($urandom_range(0, 2) == 0);
            run_change(2'($urandom), 1'($urandom), s, $urandom,
                       ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                       hold, 1'($urandom));
            if (!hold) idle($urandom_range(1, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
